crc_serial_engine: RTL

CRC_SERIAL_ENGINE -- requirements
Module: crc_serial_engine

---
 rtl/crc_pkg.sv | 19 +
 rtl/crc_step.sv | 17 +
 rtl/crc_serial_engine.sv | 105 ++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared types and defaults for the bit-serial CRC engine: FSM states, mode codes,
// and the default x^3+x+1 generator with a zero seed.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic GEN = 1'b0;
    localparam logic CHK = 1'b1;

    localparam int         DEFAULT_CRC_W = 3;
    localparam int         DEFAULT_MSG_W = 6;
    localparam logic [2:0] DEFAULT_POLY  = 3'b011;
    localparam logic [2:0] DEFAULT_INIT  = 3'b000;

endpackage

// File: rtl/crc_step.sv
// One polynomial long-division step: shift the next stream bit into the remainder and
// subtract (XOR) the generator when the outgoing top bit is set. Purely combinational.
module crc_step
    import crc_pkg::*;
#(
    parameter int             W    = DEFAULT_CRC_W,
    parameter logic [W-1:0]   POLY = W'(DEFAULT_POLY)
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    output logic [W-1:0] rem_out
);

    // Bit enters at the bottom so a zero tail of W bits leaves the true remainder.
    assign rem_out = {rem_in[W-2:0], bit_in} ^ (rem_in[W-1] ? POLY : '0);

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC generate/check, one bit per cycle; done_o pulses MSG_W+CRC_W+1 cycles after start.
// No backpressure: start_i is only sampled in IDLE. Check mode is built when CRC_CHECK_EN is defined.
module crc_serial_engine
    import crc_pkg::*;
#(
    parameter int               CRC_W = DEFAULT_CRC_W,
    parameter int               MSG_W = DEFAULT_MSG_W,
    parameter logic [CRC_W-1:0] POLY  = CRC_W'(DEFAULT_POLY),
    parameter logic [CRC_W-1:0] INIT  = CRC_W'(DEFAULT_INIT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   mode_i,
    input  logic                   abort_i,
    input  logic [MSG_W+CRC_W-1:0] data_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CRC_W-1:0]       crc_o,
    output logic                   crc_ok_o
);

    localparam int               TOTAL = MSG_W + CRC_W;
    localparam int               CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TOTAL - 1);

    state_t           state;
    logic [TOTAL-1:0] sreg;
    logic [CRC_W-1:0] rem;
    logic [CRC_W-1:0] rem_nxt;
    logic [CNT_W-1:0] cnt;
    logic [TOTAL-1:0] load_val;
    logic             ok_nxt;

`ifdef CRC_CHECK_EN
    assign load_val = (mode_i == CHK) ? data_i : {data_i[TOTAL-1:CRC_W], {CRC_W{1'b0}}};
    assign ok_nxt   = (rem_nxt == '0);
`else
    logic unused_in;
    assign unused_in = ^{mode_i, data_i[CRC_W-1:0]};
    assign load_val  = {data_i[TOTAL-1:CRC_W], {CRC_W{1'b0}}};
    assign ok_nxt    = 1'b0;
`endif

    crc_step #(
        .W    (CRC_W),
        .POLY (POLY)
    ) u_step (
        .rem_in  (rem),
        .bit_in  (sreg[TOTAL-1]),
        .rem_out (rem_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            sreg     <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            crc_o    <= '0;
            crc_ok_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sreg   <= load_val;
                        rem    <= INIT;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Abort wins even on the final bit, so a cancelled run never reports.
                    if (abort_i) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        rem  <= rem_nxt;
                        sreg <= {sreg[TOTAL-2:0], 1'b0};
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            done_o   <= 1'b1;
                            crc_o    <= rem_nxt;
                            crc_ok_o <= ok_nxt;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
